// File: rtl/rx_initiated_point_test_tx.sv
// Initiator side of the RX-initiated D2C point test: walks the start / LFSR-clear /
// count-done / end sideband exchange and runs the local pattern generator in between.
module rx_initiated_point_test_tx #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int PATTERN_CYCLES = 128
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_rx_d2c_pt_en,
    input  logic                    i_datavref_or_valvref,
    input  logic                    i_rx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_SB_Busy,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_rx_valid,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
    output logic                    o_valid_tx,
    output logic [1:0]              o_mainband_pattern_generator_cw,
    output logic                    o_valid_pattern_en,
    output logic                    o_rx_d2c_pt_done_tx
);

    localparam int CNT_W = $clog2(PATTERN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERN_CYCLES);

    typedef logic [SB_MSG_WIDTH-1:0] msg_t;

    localparam msg_t START_REQ      = msg_t'(1);
    localparam msg_t START_RESP     = msg_t'(2);
    localparam msg_t LFSR_CLR_REQ   = msg_t'(3);
    localparam msg_t LFSR_CLR_RESP  = msg_t'(4);
    localparam msg_t COUNT_DONE_REQ = msg_t'(5);
    localparam msg_t COUNT_DONE_RESP = msg_t'(6);
    localparam msg_t END_REQ        = msg_t'(7);
    localparam msg_t END_RESP       = msg_t'(8);

    localparam logic [1:0] CW_IDLE       = 2'b00;
    localparam logic [1:0] CW_CLEAR_LFSR = 2'b01;
    localparam logic [1:0] CW_LFSR       = 2'b10;

    typedef enum logic [3:0] {
        IDLE                 = 4'd0,
        SEND_START_REQ       = 4'd1,
        WAIT_START_RESP      = 4'd2,
        SEND_LFSR_CLR_REQ    = 4'd3,
        WAIT_LFSR_CLR_RESP   = 4'd4,
        SEND_PATTERN         = 4'd5,
        SEND_COUNT_DONE_REQ  = 4'd6,
        WAIT_COUNT_DONE_RESP = 4'd7,
        SEND_END_REQ         = 4'd8,
        WAIT_END_RESP        = 4'd9,
        TEST_FINISHED        = 4'd10
    } state_e;

    state_e            state_q, state_d, state_prev_q;
    msg_t              msg_q, msg_d;
    logic              valid_q, valid_d, valid_prev_q;
    logic              pending_q, pending_d;
    logic [1:0]        cw_q, cw_d;
    logic              vpe_q, vpe_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic is_send;
    logic entry;
    logic clear_all;
    logic valid_fall;
    logic resp_hit;
    msg_t req_code;
    msg_t exp_resp;

    // Outputs are registered from state_q, so they lag the state by one cycle.
    assign entry      = (state_q != state_prev_q);
    assign clear_all  = !i_rx_d2c_pt_en || (state_q == IDLE);
    assign valid_fall = valid_prev_q && !valid_q;
    assign resp_hit   = i_rx_msg_valid && (exp_resp != '0) && (i_decoded_SB_msg == exp_resp);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch can be inferred.
        is_send  = 1'b0;
        req_code = '0;
        exp_resp = '0;
        case (state_q)
            SEND_START_REQ:       begin is_send = 1'b1; req_code = START_REQ;      end
            SEND_LFSR_CLR_REQ:    begin is_send = 1'b1; req_code = LFSR_CLR_REQ;   end
            SEND_COUNT_DONE_REQ:  begin is_send = 1'b1; req_code = COUNT_DONE_REQ; end
            SEND_END_REQ:         begin is_send = 1'b1; req_code = END_REQ;        end
            WAIT_START_RESP:      exp_resp = START_RESP;
            WAIT_LFSR_CLR_RESP:   exp_resp = LFSR_CLR_RESP;
            WAIT_COUNT_DONE_RESP: exp_resp = COUNT_DONE_RESP;
            WAIT_END_RESP:        exp_resp = END_RESP;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (!i_rx_d2c_pt_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:                 state_d = SEND_START_REQ;
                SEND_START_REQ:       if (valid_fall) state_d = WAIT_START_RESP;
                WAIT_START_RESP:      if (resp_hit)   state_d = SEND_LFSR_CLR_REQ;
                SEND_LFSR_CLR_REQ:    if (valid_fall) state_d = WAIT_LFSR_CLR_RESP;
                WAIT_LFSR_CLR_RESP:   if (resp_hit)   state_d = SEND_PATTERN;
                SEND_PATTERN:         if (cnt_q == CNT_LAST) state_d = SEND_COUNT_DONE_REQ;
                SEND_COUNT_DONE_REQ:  if (valid_fall) state_d = WAIT_COUNT_DONE_RESP;
                WAIT_COUNT_DONE_RESP: if (resp_hit)   state_d = SEND_END_REQ;
                SEND_END_REQ:         if (valid_fall) state_d = WAIT_END_RESP;
                WAIT_END_RESP:        if (resp_hit)   state_d = TEST_FINISHED;
                TEST_FINISHED:        state_d = TEST_FINISHED;
                default:              state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        msg_d     = msg_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        cw_d      = CW_IDLE;
        vpe_d     = 1'b0;
        done_d    = 1'b0;
        cnt_d     = '0;

        if (clear_all) begin
            msg_d     = '0;
            pending_d = 1'b0;
        end else if (entry && is_send) begin
            msg_d = req_code;
            if (!i_SB_Busy && !i_rx_valid) begin
                valid_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end else if (pending_q) begin
            if (valid_q) begin
                pending_d = 1'b0;
            end else if (!i_rx_valid) begin
                valid_d   = 1'b1;
                pending_d = 1'b0;
            end
        end

        // A request still owned by the sideband is released only by its falling-edge pulse.
        if (state_q == IDLE && !i_SB_Busy) valid_d = 1'b0;
        if (i_falling_edge_busy)           valid_d = 1'b0;

        if (!clear_all && state_q == SEND_PATTERN) begin
            if (i_datavref_or_valvref) begin
                vpe_d = !entry;
            end else begin
                cw_d = entry ? CW_CLEAR_LFSR : CW_LFSR;
            end
        end

        if (state_q == SEND_PATTERN) begin
            cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
        end

        done_d = !clear_all && (state_q == TEST_FINISHED);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            state_prev_q <= IDLE;
            msg_q        <= '0;
            valid_q      <= 1'b0;
            valid_prev_q <= 1'b0;
            pending_q    <= 1'b0;
            cw_q         <= CW_IDLE;
            vpe_q        <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            state_prev_q <= state_q;
            msg_q        <= msg_d;
            valid_q      <= valid_d;
            valid_prev_q <= valid_q;
            pending_q    <= pending_d;
            cw_q         <= cw_d;
            vpe_q        <= vpe_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_encoded_SB_msg_tx             = msg_q;
    assign o_valid_tx                      = valid_q;
    assign o_mainband_pattern_generator_cw = cw_q;
    assign o_valid_pattern_en              = vpe_q;
    assign o_rx_d2c_pt_done_tx             = done_q;

endmodule

// File: tb/tb_rx_initiated_point_test_tx.sv
// Self-checking bench: directed handshake/abort/reset steps plus randomized full runs
// against a sideband + responder model that answers each request with code+1.
module tb_rx_initiated_point_test_tx;

    localparam int W = 4;
    localparam int P = 4;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_rx_d2c_pt_en;
    logic         i_datavref_or_valvref;
    logic         i_rx_msg_valid;
    logic [W-1:0] i_decoded_SB_msg;
    logic         i_SB_Busy;
    logic         i_falling_edge_busy;
    logic         i_rx_valid;
    logic [W-1:0] o_encoded_SB_msg_tx;
    logic         o_valid_tx;
    logic [1:0]   o_mainband_pattern_generator_cw;
    logic         o_valid_pattern_en;
    logic         o_rx_d2c_pt_done_tx;

    always #5 i_clk = ~i_clk;

    rx_initiated_point_test_tx #(
        .SB_MSG_WIDTH   (W),
        .PATTERN_CYCLES (P)
    ) dut (
        .i_clk                           (i_clk),
        .i_rst_n                         (i_rst_n),
        .i_rx_d2c_pt_en                  (i_rx_d2c_pt_en),
        .i_datavref_or_valvref           (i_datavref_or_valvref),
        .i_rx_msg_valid                  (i_rx_msg_valid),
        .i_decoded_SB_msg                (i_decoded_SB_msg),
        .i_SB_Busy                       (i_SB_Busy),
        .i_falling_edge_busy             (i_falling_edge_busy),
        .i_rx_valid                      (i_rx_valid),
        .o_encoded_SB_msg_tx             (o_encoded_SB_msg_tx),
        .o_valid_tx                      (o_valid_tx),
        .o_mainband_pattern_generator_cw (o_mainband_pattern_generator_cw),
        .o_valid_pattern_en              (o_valid_pattern_en),
        .o_rx_d2c_pt_done_tx             (o_rx_d2c_pt_done_tx)
    );

    int errors = 0;
    int checks = 0;

    bit           auto_sb;
    bit           hold_end_resp;
    int           sb_cnt;
    int           resp_cnt;
    logic [W-1:0] cur_msg;
    logic [W-1:0] resp_code;
    bit           resp8_given;
    logic [W-1:0] sent_q[$];

    int         n_clr, n_lfsr, n_vpe, n_bad;
    logic [1:0] last_cw;
    logic [1:0] cw_trace[$];
    bit         done_seen, done_early;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sideband accepts a valid request, stays busy 1..4 cycles, pulses the falling edge,
    // and the partner answers code+1 three to six cycles later.
    task automatic sb_model();
        i_falling_edge_busy = 1'b0;
        i_rx_msg_valid      = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                i_rx_msg_valid   = 1'b1;
                i_decoded_SB_msg = resp_code;
                if (resp_code == 4'd8) resp8_given = 1'b1;
            end
        end
        if (sb_cnt > 0) begin
            sb_cnt--;
            if (sb_cnt == 0) begin
                i_SB_Busy           = 1'b0;
                i_falling_edge_busy = 1'b1;
                resp_code           = cur_msg + 4'd1;
                if (!(hold_end_resp && cur_msg == 4'd7)) resp_cnt = int'($urandom_range(6, 3));
            end
        end else if (o_valid_tx && !i_SB_Busy) begin
            cur_msg = o_encoded_SB_msg_tx;
            sent_q.push_back(cur_msg);
            i_SB_Busy = 1'b1;
            sb_cnt    = int'($urandom_range(4, 1));
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        if (o_mainband_pattern_generator_cw == 2'b01) n_clr++;
        if (o_mainband_pattern_generator_cw == 2'b10) n_lfsr++;
        if (o_mainband_pattern_generator_cw == 2'b11) n_bad++;
        if (o_mainband_pattern_generator_cw != last_cw) begin
            cw_trace.push_back(o_mainband_pattern_generator_cw);
            last_cw = o_mainband_pattern_generator_cw;
        end
        if (o_valid_pattern_en) n_vpe++;
        if (o_rx_d2c_pt_done_tx && !done_seen) begin
            done_seen  = 1'b1;
            done_early = !resp8_given;
        end
        if (auto_sb) sb_model();
    endtask

    task automatic clear_monitor();
        n_clr = 0; n_lfsr = 0; n_vpe = 0; n_bad = 0;
        cw_trace.delete();
        sent_q.delete();
        last_cw     = o_mainband_pattern_generator_cw;
        done_seen   = 1'b0;
        done_early  = 1'b0;
        resp8_given = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_msg"},   32'(o_encoded_SB_msg_tx), 32'd0);
        check({tag, "_valid"}, 32'(o_valid_tx), 32'd0);
        check({tag, "_cw"},    32'(o_mainband_pattern_generator_cw), 32'd0);
        check({tag, "_vpe"},   32'(o_valid_pattern_en), 32'd0);
        check({tag, "_done"},  32'(o_rx_d2c_pt_done_tx), 32'd0);
    endtask

    task automatic run_full(input bit mode, input int idx);
        string tag;
        int    t;
        logic [1:0] exp_trace[$];
        tag = $sformatf("run%0d_%s", idx, mode ? "val" : "dat");
        i_datavref_or_valvref = mode;
        clear_monitor();
        auto_sb        = 1'b1;
        i_rx_d2c_pt_en = 1'b1;
        t = 0;
        while (!o_rx_d2c_pt_done_tx && t < 800) begin tick(); t++; end
        check({tag, "_done"}, 32'(o_rx_d2c_pt_done_tx), 32'd1);
        check({tag, "_done_after_msg8"}, 32'(done_early), 32'd0);
        check({tag, "_nmsgs"}, 32'(sent_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (sent_q.size() > k) check($sformatf("%s_msg%0d", tag, k), 32'(sent_q[k]), 32'(2 * k + 1));
        end
        check({tag, "_cw01_cycles"}, 32'(n_clr),  mode ? 32'd0 : 32'd1);
        check({tag, "_cw10_cycles"}, 32'(n_lfsr), mode ? 32'd0 : 32'(P));
        check({tag, "_vpe_cycles"},  32'(n_vpe),  mode ? 32'(P) : 32'd0);
        check({tag, "_cw11"},        32'(n_bad),  32'd0);
        if (!mode) exp_trace = '{2'b01, 2'b10, 2'b00};
        check({tag, "_cw_trace_len"}, 32'(cw_trace.size()), 32'(exp_trace.size()));
        for (int k = 0; k < exp_trace.size(); k++) begin
            if (cw_trace.size() > k) check($sformatf("%s_cw_trace%0d", tag, k), 32'(cw_trace[k]), 32'(exp_trace[k]));
        end
        i_rx_d2c_pt_en = 1'b0;
        tick();
        check({tag, "_done_clr"}, 32'(o_rx_d2c_pt_done_tx), 32'd0);
        check({tag, "_msg_clr"},  32'(o_encoded_SB_msg_tx), 32'd0);
        repeat (3) tick();
        check({tag, "_valid_idle"}, 32'(o_valid_tx), 32'd0);
    endtask

    initial begin
        int t;
        auto_sb = 1'b0; hold_end_resp = 1'b0; sb_cnt = 0; resp_cnt = 0;
        i_rst_n = 1'b0; i_rx_d2c_pt_en = 1'b0; i_datavref_or_valvref = 1'b0;
        i_rx_msg_valid = 1'b0; i_decoded_SB_msg = '0; i_SB_Busy = 1'b0;
        i_falling_edge_busy = 1'b0; i_rx_valid = 1'b0;
        clear_monitor();

        repeat (3) tick();
        check_all_zero("reset");
        i_rst_n = 1'b1;
        tick();
        check_all_zero("idle");

        // Start latency and manual sideband handshake.
        i_rx_d2c_pt_en = 1'b1;
        tick();
        check("start_lat1_valid", 32'(o_valid_tx), 32'd0);
        check("start_lat1_msg", 32'(o_encoded_SB_msg_tx), 32'd0);
        tick();
        check("start_msg", 32'(o_encoded_SB_msg_tx), 32'd1);
        check("start_valid", 32'(o_valid_tx), 32'd1);
        i_SB_Busy = 1'b1;
        tick();
        tick();
        check("busy_valid_held", 32'(o_valid_tx), 32'd1);
        i_SB_Busy = 1'b0; i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        check("feb_valid_clr", 32'(o_valid_tx), 32'd0);
        check("feb_msg_held", 32'(o_encoded_SB_msg_tx), 32'd1);
        tick();

        // Wrong and unqualified responses are ignored.
        i_rx_msg_valid = 1'b1; i_decoded_SB_msg = 4'd4;
        tick();
        i_rx_msg_valid = 1'b0; i_decoded_SB_msg = 4'd2;
        tick();
        tick();
        i_decoded_SB_msg = 4'd0;
        tick();
        check("wrong_resp_msg", 32'(o_encoded_SB_msg_tx), 32'd1);
        check("wrong_resp_valid", 32'(o_valid_tx), 32'd0);
        i_rx_msg_valid = 1'b1; i_decoded_SB_msg = 4'd2;
        tick();
        i_rx_msg_valid = 1'b0;
        tick();
        check("lfsr_req_msg", 32'(o_encoded_SB_msg_tx), 32'd3);
        check("lfsr_req_valid", 32'(o_valid_tx), 32'd1);
        i_rx_d2c_pt_en = 1'b0;
        tick();
        check("abort_msg_clr", 32'(o_encoded_SB_msg_tx), 32'd0);
        tick();
        check("abort_valid_idle", 32'(o_valid_tx), 32'd0);

        // Arbitration with the responder's valid.
        i_rx_valid = 1'b1; i_rx_d2c_pt_en = 1'b1;
        tick();
        tick();
        check("arb_msg", 32'(o_encoded_SB_msg_tx), 32'd1);
        check("arb_valid_blocked", 32'(o_valid_tx), 32'd0);
        repeat (3) tick();
        check("arb_valid_still_blocked", 32'(o_valid_tx), 32'd0);
        i_rx_valid = 1'b0;
        tick();
        check("arb_valid_rise", 32'(o_valid_tx), 32'd1);
        check("arb_msg_kept", 32'(o_encoded_SB_msg_tx), 32'd1);
        i_rx_d2c_pt_en = 1'b0;
        repeat (2) tick();
        check("arb_valid_idle", 32'(o_valid_tx), 32'd0);

        // Randomized full runs, both test flavours.
        run_full(1'b0, 0);
        run_full(1'b1, 1);
        for (int i = 2; i < 5; i++) run_full(1'($urandom_range(1, 0)), i);

        // Abort in the middle of the pattern phase.
        for (int m = 0; m < 2; m++) begin
            i_datavref_or_valvref = 1'(m);
            clear_monitor();
            auto_sb = 1'b1;
            i_rx_d2c_pt_en = 1'b1;
            t = 0;
            while (!(o_mainband_pattern_generator_cw == 2'b10 || o_valid_pattern_en) && t < 400) begin
                tick(); t++;
            end
            check($sformatf("pat_abort%0d_reached", m), 32'(t < 400), 32'd1);
            i_rx_d2c_pt_en = 1'b0;
            tick();
            check_all_zero($sformatf("pat_abort%0d", m));
            repeat (3) tick();
        end

        // Reset asserted while waiting for the end response.
        i_datavref_or_valvref = 1'b0;
        clear_monitor();
        hold_end_resp = 1'b1;
        i_rx_d2c_pt_en = 1'b1;
        t = 0;
        while (!(sent_q.size() == 4 && sb_cnt == 0 && !o_valid_tx) && t < 800) begin tick(); t++; end
        check("rst_reached_wait_end", 32'(t < 800), 32'd1);
        repeat (3) tick();
        check("rst_pre_msg", 32'(o_encoded_SB_msg_tx), 32'd7);
        check("rst_pre_done", 32'(o_rx_d2c_pt_done_tx), 32'd0);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        tick();
        i_rst_n = 1'b1;
        hold_end_resp = 1'b0;
        clear_monitor();
        t = 0;
        while (!o_valid_tx && t < 50) begin tick(); t++; end
        check("restart_valid", 32'(o_valid_tx), 32'd1);
        check("restart_msg", 32'(o_encoded_SB_msg_tx), 32'd1);
        t = 0;
        while (!o_rx_d2c_pt_done_tx && t < 800) begin tick(); t++; end
        check("restart_done", 32'(o_rx_d2c_pt_done_tx), 32'd1);
        check("restart_nmsgs", 32'(sent_q.size()), 32'd4);
        i_rx_d2c_pt_en = 1'b0;
        tick();
        check("restart_done_clr", 32'(o_rx_d2c_pt_done_tx), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_initiated_point_test_tx.md
# rx_initiated_point_test_tx

Initiator side of the RX-initiated data-to-clock (D2C) point test. When the LTSM enables it, the block drives the full sideband request sequence toward the link partner: start, LFSR clear, count done, end. Between the LFSR-clear and count-done exchanges it drives the local mainband pattern generator (data lanes) or the valid-pattern generator (valid lane) for a fixed number of cycles. It shares the sideband wrapper with the responder block of the same test and arbitrates with it through the valid handshake.

## Interface
- SB_MSG_WIDTH, 4, width of encoded/decoded sideband message codes
- PATTERN_CYCLES, 128, number of cycles the generator runs in LFSR mode (≥1)

- i_clk  in  1  block clock
- i_rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- i_rx_d2c_pt_en  in  1  LTSM enable; deassertion aborts to IDLE from any state
- i_datavref_or_valvref  in  1  0: data-lane vref test, 1: valid-lane vref test
- i_rx_msg_valid  in  1  qualifies i_decoded_SB_msg
- i_decoded_SB_msg  in  SB_MSG_WIDTH  decoded partner message
- i_SB_Busy  in  1  sideband currently transmitting
- i_falling_edge_busy  in  1  one-cycle pulse: sideband finished sending the current message
- i_rx_valid  in  1  responder block's valid toward the wrapper, used for arbitration
- o_encoded_SB_msg_tx  out  SB_MSG_WIDTH  request code presented to the sideband
- o_valid_tx  out  1  request on o_encoded_SB_msg_tx is valid
- o_mainband_pattern_generator_cw  out  2  00 IDLE, 01 CLEAR_LFSR, 10 LFSR, 11 unused
- o_valid_pattern_en  out  1  enables the valid-lane pattern generator
- o_rx_d2c_pt_done_tx  out  1  test complete, held until enable drops

## Operation
- Message codes:
  - 1 START_RX_D2C_PT_REQ, 2 START_RX_D2C_PT_RESP
  - 3 LFSR_CLR_ERROR_REQ, 4 LFSR_CLR_ERROR_RESP
  - 5 COUNT_DONE_REQ, 6 COUNT_DONE_RESP
  - 7 END_RX_D2C_PT_REQ, 8 END_RX_D2C_PT_RESP
- States and transitions (each takes effect only while enable=1; otherwise next state is IDLE):
  - IDLE → SEND_START_REQ on enable.
  - SEND_START_REQ → WAIT_START_RESP on falling edge of o_valid_tx.
  - WAIT_START_RESP → SEND_LFSR_CLR_REQ on i_rx_msg_valid with msg=2.
  - SEND_LFSR_CLR_REQ → WAIT_LFSR_CLR_RESP on falling edge of o_valid_tx.
  - WAIT_LFSR_CLR_RESP → SEND_PATTERN on i_rx_msg_valid with msg=4.
  - SEND_PATTERN → SEND_COUNT_DONE_REQ when the counter reaches PATTERN_CYCLES.
  - SEND_COUNT_DONE_REQ → WAIT_COUNT_DONE_RESP on falling edge of o_valid_tx.
  - WAIT_COUNT_DONE_RESP → SEND_END_REQ on msg=6.
  - SEND_END_REQ → WAIT_END_RESP on falling edge of o_valid_tx.
  - WAIT_END_RESP → TEST_FINISHED on msg=8.
  - TEST_FINISHED → IDLE when enable drops.
  - Unused encodings → IDLE.
- Messages that do not match the awaited code, or arrive without i_rx_msg_valid, are ignored.
- o_encoded_SB_msg_tx is loaded with the request code on the cycle a SEND_* state is entered. It is held until the next load, and cleared to 0 in IDLE.
- Valid handshake:
  - o_valid_tx is set on SEND_* entry if i_SB_Busy=0 and i_rx_valid=0.
  - Otherwise a pending flag is set, and o_valid_tx is raised on the first cycle with pending=1 and i_rx_valid=0. Pending clears once o_valid_tx=1.
  - o_valid_tx is cleared on i_falling_edge_busy. Clear has priority over set.
  - The falling edge of o_valid_tx is detected with a one-cycle-delayed copy.
- Pattern phase, data test (i_datavref_or_valvref=0):
  - cw=01 for exactly 1 cycle on SEND_PATTERN entry.
  - Then cw=10 for PATTERN_CYCLES cycles.
  - cw returns to 00 on entry to SEND_COUNT_DONE_REQ.
- Pattern phase, valid test (i_datavref_or_valvref=1):
  - cw stays 00.
  - o_valid_pattern_en=1 for PATTERN_CYCLES cycles, then 0.
- Counter: width $clog2(PATTERN_CYCLES+1), cleared outside SEND_PATTERN, no wrap.
- o_rx_d2c_pt_done_tx is set on entry to TEST_FINISHED and cleared in IDLE.
- Abort: enable=0 in any state sends the block to IDLE next cycle. All outputs except o_valid_tx clear there. o_valid_tx still waits for i_falling_edge_busy, or clears in IDLE if no message is in flight.

## Timing
- Reset values: all outputs 0, state IDLE, pending 0, counter 0.
- Enable sampled high at edge N gives SEND_START_REQ at N+1. msg=1 and o_valid_tx=1 at N+2 if the sideband is free.
- Response with msg valid at edge M gives the next SEND_* state at M+1, and request/valid registered at M+2.
- Pattern phase lasts 1+PATTERN_CYCLES cycles (data) or PATTERN_CYCLES cycles (valid).
- i_falling_edge_busy at edge K gives o_valid_tx=0 at K+1 and the state advance at K+2.

## Test plan
- Full data test, PATTERN_CYCLES=4, responder answers 2/4/6/8 after 3 cycles:
  - msgs 1,3,5,7 issued in order.
  - cw shows 01 ×1 cycle, then 10 ×4 cycles, then 00.
  - done=1 after msg 8.
- Valid test (i_datavref_or_valvref=1): cw stays 00, o_valid_pattern_en high exactly 4 cycles.
- Arbitration:
  - i_rx_valid=1 on SEND_START_REQ entry: o_valid_tx stays 0.
  - o_valid_tx rises one cycle after i_rx_valid falls; msg=1 unchanged.
- Wrong/unqualified response:
  - msg=4 in WAIT_START_RESP, or msg=2 with i_rx_msg_valid=0: state holds.
  - Correct msg=2 then advances.
- Abort: enable dropped mid-SEND_PATTERN gives IDLE next cycle, with cw=00, msg=0, done=0.
- Reset asserted in WAIT_END_RESP: all outputs 0 immediately; re-enable restarts from msg=1.
